// File: rtl/pipeline_if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Fetch-queue entry layout and fetch FSM state encodings live here.
package pipeline_if_pkg;

  localparam int COMMON_WIDTH = 32;

  localparam logic [COMMON_WIDTH-1:0] NOP_INST = 32'h0000_0013;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL = 7'b1101111;
  localparam logic [COMMON_WIDTH-1:0] PC_MASK = 32'hFFFF_FFFC;

  typedef enum logic {
    IF_STATE_FETCH = 1'b0,
    IF_STATE_DISCARD = 1'b1
  } if_state_e;

  typedef struct packed {
    logic [COMMON_WIDTH-1:0] pc;
    logic [COMMON_WIDTH-1:0] inst;
    logic pred_taken;
  } if_entry_t;

endpackage

// File: rtl/if_fetch_queue.sv
// Small synchronous FIFO of fetched {pc,inst,pred_taken} entries.
// Flush dominates push and pop; depth must be a power of two.
module if_fetch_queue
  import pipeline_if_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  if_entry_t                push_entry,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output if_entry_t                head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  if_entry_t     mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_entry;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/pipeline_if.sv
// Instruction-fetch stage: PC generation, imem req/ack, fetch queue.
// Static branch prediction is built when IF_STATIC_PREDICT_EN is defined.
module pipeline_if
  import pipeline_if_pkg::*;
#(
  parameter logic [COMMON_WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    imem_req,
  output logic [COMMON_WIDTH-1:0] imem_addr,
  input  logic                    imem_ack,
  input  logic [COMMON_WIDTH-1:0] imem_data,
  input  logic                    stall_id,
  input  logic                    redirect,
  input  logic [COMMON_WIDTH-1:0] redirect_pc,
  output logic                    inst_valid,
  output logic [COMMON_WIDTH-1:0] inst,
  output logic [COMMON_WIDTH-1:0] pc,
  output logic                    pred_taken
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(QUEUE_DEPTH);

  if_state_e               state;
  logic                    run;
  logic [COMMON_WIDTH-1:0] fetch_pc;
  logic [COMMON_WIDTH-1:0] req_addr;
  logic [COMMON_WIDTH-1:0] next_pc;
  logic                    pred;
  logic [CW-1:0]           q_count;
  logic                    q_valid;
  logic                    fire;
  if_entry_t               push_entry;
  if_entry_t               head;

`ifdef IF_STATIC_PREDICT_EN
  logic [6:0]              opcode;
  logic [COMMON_WIDTH-1:0] j_imm;
  logic [COMMON_WIDTH-1:0] b_imm;

  always_comb begin
    opcode = imem_data[6:0];
    j_imm = {{12{imem_data[31]}}, imem_data[19:12],
             imem_data[20], imem_data[30:21], 1'b0};
    b_imm = {{20{imem_data[31]}}, imem_data[7],
             imem_data[30:25], imem_data[11:8], 1'b0};
    pred = 1'b0;
    next_pc = fetch_pc + 32'd4;
    unique case (1'b1)
      (opcode == OPCODE_JAL): begin
        pred = 1'b1;
        next_pc = fetch_pc + j_imm;
      end
      (opcode == OPCODE_BRANCH && imem_data[31]): begin
        pred = 1'b1;
        next_pc = fetch_pc + b_imm;
      end
      default: ;
    endcase
  end
`else
  assign pred = 1'b0;
  assign next_pc = fetch_pc + 32'd4;
`endif

  // run holds requests off for the first cycle after reset release
  always_comb begin
    imem_req = 1'b0;
    imem_addr = fetch_pc;
    unique case (state)
      IF_STATE_FETCH: imem_req = run && (q_count < FULL_CNT);
      IF_STATE_DISCARD: begin
        imem_req = 1'b1;
        imem_addr = req_addr;
      end
      default: ;
    endcase
  end

  assign fire = (state == IF_STATE_FETCH) && imem_req && imem_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IF_STATE_FETCH;
      run      <= 1'b0;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      run <= 1'b1;
      if (redirect) fetch_pc <= redirect_pc & PC_MASK;
      unique case (state)
        IF_STATE_FETCH: begin
          if (redirect) begin
            if (imem_req && !imem_ack) begin
              state    <= IF_STATE_DISCARD;
              req_addr <= fetch_pc;
            end
          end else if (fire) begin
            fetch_pc <= next_pc;
          end
        end
        IF_STATE_DISCARD: begin
          if (imem_ack) state <= IF_STATE_FETCH;
        end
        default: state <= IF_STATE_FETCH;
      endcase
    end
  end

  assign push_entry = {fetch_pc, imem_data, pred};

  if_fetch_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (fire && !redirect),
    .push_entry(push_entry),
    .pop       (q_valid && !stall_id),
    .flush     (redirect),
    .count     (q_count),
    .head      (head)
  );

  assign q_valid = (q_count != '0);
  assign inst_valid = q_valid;
  assign inst = q_valid ? head.inst : NOP_INST;
  assign pc = q_valid ? head.pc : '0;
  assign pred_taken = q_valid && head.pred_taken;

endmodule

// File: tb/tb_pipeline_if.sv
// Bench for pipeline_if: directed fetch scenarios plus random
// stall/redirect/latency traffic checked against a program-order model.
module tb_pipeline_if;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] BEQ_BACK = 32'hFE000CE3;
  localparam logic [31:0] BEQ_FWD = 32'h00000463;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        stall_id;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        pred_taken;

  int total = 0;
  int bad = 0;

  int mwait;
  int lat;
  int mem_lo;
  int mem_hi;
  logic [31:0] sp_addr;
  logic [31:0] sp_word;

  logic [31:0] exp_pc;
  int accepts;
  int idle;

  always #5 clk = ~clk;

  pipeline_if #(
    .RESET_PC(32'h0000_0000),
    .QUEUE_DEPTH(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .stall_id   (stall_id),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .inst_valid (inst_valid),
    .inst       (inst),
    .pc         (pc),
    .pred_taken (pred_taken)
  );

  // memory: one special word, all others are addr-derived addi's
  always_comb begin
    imem_data = (imem_addr == sp_addr) ? sp_word
                                       : {imem_addr[24:0], 7'h13};
  end

  always_comb imem_ack = imem_req && (mwait >= lat);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mwait <= 0;
      lat <= mem_lo;
    end else if (!imem_req || imem_ack) begin
      mwait <= 0;
      lat <= int'($urandom_range(mem_hi, mem_lo));
    end else begin
      mwait <= mwait + 1;
    end
  end

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a == sp_addr) ? sp_word : {a[24:0], 7'h13};
  endfunction

`ifdef IF_STATIC_PREDICT_EN
  function automatic logic taken_at(input logic [31:0] a);
    logic [31:0] w;
    w = word_at(a);
    return (w[6:0] == 7'b1101111) || (w[6:0] == 7'b1100011 && w[31]);
  endfunction

  function automatic logic [31:0] target_at(input logic [31:0] a);
    logic [31:0] w;
    w = word_at(a);
    if (!taken_at(a)) return a + 32'd4;
    if (w[6:0] == 7'b1101111)
      return a + {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
    return a + {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
  endfunction
`else
  function automatic logic taken_at(input logic [31:0] a);
    return (a == 32'h1);
  endfunction

  function automatic logic [31:0] target_at(input logic [31:0] a);
    return a + 32'd4;
  endfunction
`endif

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // one cycle: model checks at negedge, then advance past posedge
  task automatic step();
    @(negedge clk);
    if (rst) begin
      if (redirect) begin
        exp_pc = redirect_pc & 32'hFFFF_FFFC;
        idle = 0;
      end else if (inst_valid && !stall_id) begin
        check_eq("pc", pc, exp_pc);
        check_eq("inst", inst, word_at(exp_pc));
        check_eq("pred", {31'b0, pred_taken}, {31'b0, taken_at(exp_pc)});
        exp_pc = target_at(exp_pc);
        accepts++;
        idle = 0;
      end else begin
        if (!inst_valid) begin
          check_eq("nop_inst", inst, NOP);
          check_eq("nop_pc", pc, 32'h0);
        end
        if (!stall_id) begin
          idle++;
          if (idle == 60) check_eq("progress", idle, 0);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    int n;
    stall_id = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    mem_lo = 0;
    mem_hi = 0;
    sp_addr = 32'h1;
    sp_word = '0;
    exp_pc = '0;
    accepts = 0;
    idle = 0;

    // reset values and first fetches
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_req", imem_req, 0);
    check_eq("rst_valid", inst_valid, 0);
    check_eq("rst_inst", inst, NOP);
    check_eq("rst_pc", pc, 0);
    rst = 1'b1;
    step();
    check_eq("t1_req", imem_req, 1);
    check_eq("t1_addr0", imem_addr, 32'h0);
    check_eq("t1_valid0", inst_valid, 0);
    step();
    check_eq("t1_addr4", imem_addr, 32'h4);
    check_eq("t1_valid", inst_valid, 1);
    check_eq("t1_pc0", pc, 32'h0);
    step();
    check_eq("t1_addr8", imem_addr, 32'h8);
    check_eq("t1_pc4", pc, 32'h4);
    check_eq("t1_inst4", inst, word_at(32'h4));

    // stall fills the queue and freezes the head
    stall_id = 1'b1;
    repeat (5) step();
    check_eq("t2_req", imem_req, 0);
    check_eq("t2_valid", inst_valid, 1);
    check_eq("t2_pc", pc, 32'h4);
    check_eq("t2_inst", inst, word_at(32'h4));
    stall_id = 1'b0;
    repeat (4) step();

    // static prediction of a backward then a forward branch
    sp_addr = 32'h20;
    sp_word = BEQ_BACK;
    redirect = 1'b1;
    redirect_pc = 32'h20;
    step();
    redirect = 1'b0;
    check_eq("t5_addr", imem_addr, 32'h20);
    step();
    check_eq("t5_pc", pc, 32'h20);
`ifdef IF_STATIC_PREDICT_EN
    check_eq("t5_back_addr", imem_addr, 32'h18);
    check_eq("t5_back_pred", pred_taken, 1);
`else
    check_eq("t5_back_addr", imem_addr, 32'h24);
    check_eq("t5_back_pred", pred_taken, 0);
`endif
    repeat (8) step();
    sp_word = BEQ_FWD;
    redirect = 1'b1;
    step();
    redirect = 1'b0;
    step();
    check_eq("t5_fwd_pc", pc, 32'h20);
    check_eq("t5_fwd_addr", imem_addr, 32'h24);
    check_eq("t5_fwd_pred", pred_taken, 0);
    repeat (4) step();

    // redirect together with stall on a full queue
    stall_id = 1'b1;
    repeat (3) step();
    check_eq("t4_full_req", imem_req, 0);
    redirect = 1'b1;
    redirect_pc = 32'h200;
    sp_addr = 32'h1;
    step();
    redirect = 1'b0;
    stall_id = 1'b0;
    check_eq("t4_flush", inst_valid, 0);
    check_eq("t4_addr", imem_addr, 32'h200);
    step();
    check_eq("t4_valid", inst_valid, 1);
    check_eq("t4_pc", pc, 32'h200);
    repeat (4) step();

    // redirect during a slow request: stale response is discarded
    mem_lo = 3;
    mem_hi = 3;
    redirect = 1'b1;
    redirect_pc = 32'h0;
    step();
    redirect = 1'b0;
    found = 0;
    for (int i = 0; i < 60; i++) begin
      if (imem_req && !imem_ack && imem_addr == 32'h8) begin
        found = 1;
        break;
      end
      step();
    end
    check_eq("t3_pending", found, 1);
    redirect = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    check_eq("t3_valid", inst_valid, 0);
    check_eq("t3_hold_req", imem_req, 1);
    check_eq("t3_hold_addr", imem_addr, 32'h8);
    n = 0;
    while (imem_req && imem_addr == 32'h8 && n < 10) begin
      step();
      n++;
    end
    check_eq("t3_drain", n, 3);
    check_eq("t3_new_addr", imem_addr, 32'h100);
    repeat (12) step();

    // reset in the middle of a pending request
    found = 0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req && !imem_ack) begin
        found = 1;
        break;
      end
      step();
    end
    check_eq("t6_pending", found, 1);
    rst = 1'b0;
    #1;
    check_eq("t6_req", imem_req, 0);
    check_eq("t6_valid", inst_valid, 0);
    check_eq("t6_inst", inst, NOP);
    check_eq("t6_pc", pc, 0);
    repeat (2) @(posedge clk);
    #1;
    mem_lo = 0;
    mem_hi = 3;
    rst = 1'b1;
    exp_pc = '0;
    idle = 0;
    step();
    check_eq("t6_refetch", imem_addr, 32'h0);
    check_eq("t6_refetch_req", imem_req, 1);

    // random stall / redirect / latency traffic
    for (int i = 0; i < 500; i++) begin
      stall_id = ($urandom % 10) < 3;
      redirect = ($urandom % 25) == 0;
      if (redirect) begin
        if ($urandom % 4 == 0)
          redirect_pc = 32'hFFFF_FFF0 | ($urandom % 16);
        else
          redirect_pc = $urandom;
      end
      step();
    end
    stall_id = 1'b0;
    redirect = 1'b0;
    repeat (30) step();
    check_eq("accepts", (accepts > 50) ? 1 : 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
